y4_mb_collect: RTL and testbench
================================

Name: y4_mb_collect

Overview:
- Downstream of the 4x4 luma reconstruct stage. Accepts the 16 reconstructed 4x4 luma sub-blocks of one macroblock in raster order.
- Assembles them into a 16x16 reconstructed macroblock and records the per-block nz flags.
- Continuously presents the top/left/top-left/top-right neighbour pixels that the intra-4x4 predictor needs for the next sub-block.
- Pulses done when the macroblock is complete.

Parameters:
- BLOCK_SIZE, 4, sub-block edge in pixels. Fixed; other values unsupported.
- MB_SIZE, 16, macroblock edge in pixels.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; latch edges, clear state, begin new macroblock
- top_mb  in  160  row above MB: bytes 0..15 above cols 0..15, bytes 16..19 above-right MB cols 0..3
- left_mb  in  128  column left of MB, byte r = row r
- top_left_mb  in  8  pixel above-left of MB
- in_valid  in  1  one-cycle pulse with a finished sub-block (driven by reconstruct done)
- Yin  in  128  reconstructed 4x4, byte i = pixel (i/4, i%4)
- nz_in  in  1  nonzero flag of that sub-block
- busy  out  1  macroblock in progress
- blk_idx  out  4  index of next expected sub-block, row-major (row = idx[3:2], col = idx[1:0])
- nb_top  out  64  bytes 0..3 above current block, bytes 4..7 above-right
- nb_left  out  32  byte r = pixel left of row r
- nb_top_left  out  8  pixel above-left of current block
- Y16  out  2048  assembled MB, byte r*16+c = pixel (r,c)
- nz_mask  out  16  bit k = nz_in of sub-block k
- done  out  1  one-cycle pulse, MB complete

Behaviour:
- Reset: busy=0, blk_idx=0, Y16=0, nz_mask=0, done=0. Latched edges = 0, so nb_* = 0.
- start: next cycle busy=1, blk_idx=0, nz_mask=0. top_mb/left_mb/top_left_mb are registered. Y16 is not cleared.
- start while busy restarts the MB. Partial data is discarded logically and no done is produced.
- start and in_valid in the same cycle: start wins and in_valid is dropped.
- in_valid while busy: write Yin into Y16 at rows 4*idx[3:2].., cols 4*idx[1:0].., and set nz_mask[idx]=nz_in. Next cycle blk_idx increments.
- Accepting block 15: next cycle blk_idx wraps to 0, busy=0, done=1 for exactly one cycle. Y16 and nz_mask hold until the next start.
- in_valid while idle is ignored.
- nb_* is combinational from registered state and valid while busy. With R=idx[3:2], C=idx[1:0], x0=4C, y0=4R:
  - nb_top: if R=0, top_mb bytes x0..x0+3; else Y16 row y0-1, cols x0..x0+3.
  - nb_top right half (bytes 4..7):
    - R=0: top_mb bytes x0+4..x0+7. For C=3 these are bytes 16..19.
    - R>0 and C<3: Y16 row y0-1, cols x0+4..x0+7.
    - R>0 and C=3: top_mb bytes 16..19 (VP8 rule).
  - nb_left: if C=0, left_mb bytes y0..y0+3; else Y16 col x0-1, rows y0..y0+3.
  - nb_top_left:
    - R=0, C=0: top_left_mb.
    - R=0, C>0: top_mb byte x0-1.
    - R>0, C=0: left_mb byte y0-1.
    - otherwise: Y16 (y0-1, x0-1).
- Latency: a sub-block accepted in cycle t is reflected in nb_*, blk_idx and Y16 at t+1. That is soon enough for back-to-back blocks, since the reconstruct stage takes several cycles per block.
- Reset asserted mid-MB: all state clears asynchronously and no done is produced.

Decomposition:
- Shared package holds constants MB_SIZE=16, BLOCK_SIZE=4, NUM_SUBBLK=16, and the pixel-index helpers.
- One sub-module, y4_nb_select: the purely combinational neighbour mux, taking idx, Y16 and the latched edges. It can be verified standalone.

Test Plan:
- Reset then idle, in_valid pulsed -> busy=0, blk_idx=0, nz_mask=0, no done.
- start with top_mb byte k=k, left_mb byte r=0x40+r, top_left_mb=0x80 -> block 0: nb_top=00..07, nb_left=40..43, nb_top_left=80.
- Feed 16 blocks, block k filled with byte value k, nz_in=k[0] -> block 5 (R1,C1): nb_top=01,01,01,01,02,02,02,02, nb_left=04 x4, nb_top_left=00. Block 7: nb_top right half = bytes 10..13 of top_mb (16..19). After block 15: done single pulse, nz_mask=0xAAAA, Y16(15,15)=0x0F.
- start after block 8 of an MB -> blk_idx=0, nz_mask=0, and done appears only after 16 further blocks.
- start and in_valid in the same cycle -> block dropped, blk_idx=0 next cycle.
- rst_n low after block 3 -> busy=0, blk_idx=0, nz_mask=0 immediately; no done.

Source files
------------

// File: rtl/y4_mb_collect_pkg.sv
// y4_mb_collect_pkg: macroblock geometry constants and pixel-index helpers
package y4_mb_collect_pkg;
  localparam int MB_SIZE    = 16;
  localparam int BLOCK_SIZE = 4;
  localparam int NUM_SUBBLK = 16;
  localparam int MB_BITS    = MB_SIZE * MB_SIZE * 8;
  localparam int BLK_BITS   = BLOCK_SIZE * BLOCK_SIZE * 8;
  function automatic logic [7:0] y_px(input logic [MB_BITS-1:0] y, input logic [3:0] r, input logic [3:0] c);
    return y[{r, c, 3'b000} +: 8];
  endfunction
  function automatic logic [7:0] top_px(input logic [159:0] t, input logic [4:0] k);
    return t[{k, 3'b000} +: 8];
  endfunction
  function automatic logic [7:0] left_px(input logic [127:0] l, input logic [3:0] k);
    return l[{k, 3'b000} +: 8];
  endfunction
endpackage

// File: rtl/y4_mb_collect_nb_select.sv
// y4_nb_select: combinational intra-4x4 neighbour mux for the current sub-block
module y4_nb_select
  import y4_mb_collect_pkg::*;
(
  input  logic [3:0]         idx,
  input  logic [MB_BITS-1:0] Y16,
  input  logic [159:0]       top_mb,
  input  logic [127:0]       left_mb,
  input  logic [7:0]         top_left_mb,
  output logic [63:0]        nb_top,
  output logic [31:0]        nb_left,
  output logic [7:0]         nb_top_left
);
  logic       r0, c0, c3;
  logic [3:0] y0, x0, yu, xl;
  assign r0 = idx[3:2] == 2'd0;
  assign c0 = idx[1:0] == 2'd0;
  assign c3 = idx[1:0] == 2'd3;
  assign y0 = {idx[3:2], 2'b00};
  assign x0 = {idx[1:0], 2'b00};
  assign yu = y0 - 4'd1;
  assign xl = x0 - 4'd1;
  always_comb begin
    nb_top  = '0;
    nb_left = '0;
    for (int i = 0; i < 4; i++) begin
      nb_top[8*i +: 8]     = r0 ? top_px(top_mb, {1'b0, x0} + 5'(i)) : y_px(Y16, yu, x0 + 4'(i));
      nb_top[8*i+32 +: 8]  = r0 ? top_px(top_mb, {1'b0, x0} + 5'(i + 4)) :
                             c3 ? top_px(top_mb, 5'(16 + i)) : y_px(Y16, yu, x0 + 4'(i + 4));
      nb_left[8*i +: 8]    = c0 ? left_px(left_mb, y0 + 4'(i)) : y_px(Y16, y0 + 4'(i), xl);
    end
    nb_top_left = r0 ? (c0 ? top_left_mb : top_px(top_mb, {1'b0, xl})) :
                       (c0 ? left_px(left_mb, yu) : y_px(Y16, yu, xl));
  end
endmodule

// File: rtl/y4_mb_collect.sv
// y4_mb_collect: assemble 16 reconstructed 4x4 luma blocks into a macroblock with live neighbours
module y4_mb_collect
  import y4_mb_collect_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [159:0]        top_mb,
  input  logic [127:0]        left_mb,
  input  logic [7:0]          top_left_mb,
  input  logic                in_valid,
  input  logic [BLK_BITS-1:0] Yin,
  input  logic                nz_in,
  output logic                busy,
  output logic [3:0]          blk_idx,
  output logic [63:0]         nb_top,
  output logic [31:0]         nb_left,
  output logic [7:0]          nb_top_left,
  output logic [MB_BITS-1:0]  Y16,
  output logic [15:0]         nz_mask,
  output logic                done
);
  logic [159:0] top_q;
  logic [127:0] left_q;
  logic [7:0]   tl_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      blk_idx <= '0;
      Y16     <= '0;
      nz_mask <= '0;
      done    <= 1'b0;
      top_q   <= '0;
      left_q  <= '0;
      tl_q    <= '0;
    end else if (start) begin
      busy    <= 1'b1;
      blk_idx <= '0;
      nz_mask <= '0;
      done    <= 1'b0;
      top_q   <= top_mb;
      left_q  <= left_mb;
      tl_q    <= top_left_mb;
    end else begin
      done <= 1'b0;
      if (in_valid && busy) begin
        for (int i = 0; i < BLOCK_SIZE; i++)
          Y16[{blk_idx[3:2], 2'(i), blk_idx[1:0], 2'b00, 3'b000} +: 32] <= Yin[32*i +: 32];
        nz_mask[blk_idx] <= nz_in;
        blk_idx          <= blk_idx + 4'd1;
        if (blk_idx == 4'(NUM_SUBBLK - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end
  y4_nb_select u_nb (
    .idx         (blk_idx),
    .Y16         (Y16),
    .top_mb      (top_q),
    .left_mb     (left_q),
    .top_left_mb (tl_q),
    .nb_top      (nb_top),
    .nb_left     (nb_left),
    .nb_top_left (nb_top_left)
  );
endmodule

// File: tb/tb_y4_mb_collect.sv
// tb_y4_mb_collect: directed bench with a padded-picture reference model
module tb_y4_mb_collect;
  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [159:0]   top_mb = '0;
  logic [127:0]   left_mb = '0;
  logic [7:0]     top_left_mb = '0;
  logic           in_valid = 1'b0;
  logic [127:0]   Yin = '0;
  logic           nz_in = 1'b0;
  logic           busy;
  logic [3:0]     blk_idx;
  logic [63:0]    nb_top;
  logic [31:0]    nb_left;
  logic [7:0]     nb_top_left;
  logic [2047:0]  Y16;
  logic [15:0]    nz_mask;
  logic           done;
  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0]  m_y [16][16];
  logic [7:0]  m_top [20];
  logic [7:0]  m_left [16];
  logic [7:0]  m_tl;
  logic        m_busy, m_done;
  int          m_idx;
  logic [15:0] m_nz;

  y4_mb_collect dut (
    .clk(clk), .rst_n(rst_n), .start(start), .top_mb(top_mb), .left_mb(left_mb),
    .top_left_mb(top_left_mb), .in_valid(in_valid), .Yin(Yin), .nz_in(nz_in),
    .busy(busy), .blk_idx(blk_idx), .nb_top(nb_top), .nb_left(nb_left),
    .nb_top_left(nb_top_left), .Y16(Y16), .nz_mask(nz_mask), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Picture around the MB: row -1 is the edge row, column -1 the edge column,
  // and columns 16..19 always come from the above-right edge bytes.
  function automatic logic [7:0] pad(input int r, input int c);
    if (c >= 16) return m_top[c];
    if (r < 0 && c < 0) return m_tl;
    if (r < 0) return m_top[c];
    if (c < 0) return m_left[r];
    return m_y[r][c];
  endfunction

  task automatic mreset();
    m_busy = 0; m_done = 0; m_idx = 0; m_nz = '0; m_tl = '0;
    for (int r = 0; r < 16; r++) begin
      m_left[r] = '0;
      for (int c = 0; c < 16; c++) m_y[r][c] = '0;
    end
    for (int c = 0; c < 20; c++) m_top[c] = '0;
  endtask

  task automatic mstep(input logic st, input logic iv, input logic [127:0] d, input logic nz);
    if (st) begin
      m_busy = 1; m_done = 0; m_idx = 0; m_nz = '0; m_tl = top_left_mb;
      for (int c = 0; c < 20; c++) m_top[c] = top_mb[8*c +: 8];
      for (int r = 0; r < 16; r++) m_left[r] = left_mb[8*r +: 8];
    end else begin
      m_done = 0;
      if (iv && m_busy) begin
        for (int p = 0; p < 16; p++) m_y[4*(m_idx/4) + p/4][4*(m_idx%4) + p%4] = d[8*p +: 8];
        m_nz[m_idx] = nz;
        m_idx = (m_idx + 1) % 16;
        if (m_idx == 0) begin
          m_busy = 0;
          m_done = 1;
        end
      end
    end
  endtask

  task automatic step(input logic st, input logic iv, input logic [127:0] d, input logic nz);
    start = st; in_valid = iv; Yin = d; nz_in = nz;
    @(posedge clk);
    mstep(st, iv, d, nz);
    #1;
    start = 0; in_valid = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, '0, 0);
  endtask

  task automatic blk(input int v, input logic nz);
    step(0, 1, {16{8'(v)}}, nz);
    idle(2);
  endtask

  always @(negedge clk) begin
    int bad_at;
    logic [63:0] et;
    logic [31:0] el;
    chk("busy", 64'(busy), 64'(m_busy));
    chk("done", 64'(done), 64'(m_done));
    chk("nz_mask", 64'(nz_mask), 64'(m_nz));
    bad_at = -1;
    for (int k = 0; k < 256; k++)
      if (bad_at < 0 && Y16[8*k +: 8] !== m_y[k/16][k%16]) bad_at = k;
    n_cmp++;
    if (bad_at >= 0) begin
      n_bad++;
      $display("FAIL Y16 at %0t: byte %0d got %0h expected %0h", $time, bad_at,
               Y16[8*bad_at +: 8], m_y[bad_at/16][bad_at%16]);
    end
    if (m_busy) begin
      chk("blk_idx", 64'(blk_idx), 64'(m_idx));
      for (int i = 0; i < 8; i++) et[8*i +: 8] = pad(4*(m_idx/4) - 1, 4*(m_idx%4) + i);
      for (int i = 0; i < 4; i++) el[8*i +: 8] = pad(4*(m_idx/4) + i, 4*(m_idx%4) - 1);
      chk("nb_top", nb_top, et);
      chk("nb_left", 64'(nb_left), 64'(el));
      chk("nb_top_left", 64'(nb_top_left), 64'(pad(4*(m_idx/4) - 1, 4*(m_idx%4) - 1)));
    end
  end

  initial begin
    mreset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    chk("rst_busy", 64'(busy), 0);
    chk("rst_idx", 64'(blk_idx), 0);
    chk("rst_nz", 64'(nz_mask), 0);
    chk("rst_y16_nonzero", 64'(|Y16), 0);
    step(0, 1, {16{8'hFF}}, 1);
    idle(1);
    chk("idle_busy", 64'(busy), 0);
    chk("idle_idx", 64'(blk_idx), 0);
    chk("idle_nz", 64'(nz_mask), 0);
    for (int k = 0; k < 20; k++) top_mb[8*k +: 8] = 8'(k);
    for (int r = 0; r < 16; r++) left_mb[8*r +: 8] = 8'(8'h40 + r);
    top_left_mb = 8'h80;
    step(1, 0, '0, 0);
    chk("b0_top", nb_top, 64'h0706050403020100);
    chk("b0_left", 64'(nb_left), 64'h43424140);
    chk("b0_tl", 64'(nb_top_left), 64'h80);
    for (int k = 0; k < 16; k++) begin
      if (k == 5) begin
        chk("b5_top", nb_top, 64'h0202020201010101);
        chk("b5_left", 64'(nb_left), 64'h04040404);
        chk("b5_tl", 64'(nb_top_left), 64'h00);
      end
      if (k == 7) chk("b7_top", nb_top, 64'h1312111003030303);
      step(0, 1, {16{8'(k)}}, k[0]);
      if (k == 15) chk("done_pulse", 64'(done), 1);
      idle(2);
    end
    chk("done_single", 64'(done), 0);
    chk("nz_final", 64'(nz_mask), 64'hAAAA);
    chk("y16_15_15", 64'(Y16[2047:2040]), 64'h0F);
    top_left_mb = 8'h9C;
    for (int k = 0; k < 20; k++) top_mb[8*k +: 8] = 8'(8'hA0 + 3*k);
    step(1, 0, '0, 0);
    for (int k = 0; k < 9; k++) blk(8'h20 + k, 1);
    step(1, 0, '0, 0);
    chk("restart_idx", 64'(blk_idx), 0);
    chk("restart_nz", 64'(nz_mask), 0);
    for (int k = 0; k < 16; k++) blk(8'h30 + 7*k, k[1]);
    chk("restart_nz_final", 64'(nz_mask), 64'hCCCC);
    step(1, 0, '0, 0);
    for (int k = 0; k < 3; k++) blk(8'h50 + k, 1);
    step(1, 1, {16{8'hEE}}, 1);
    chk("collide_idx", 64'(blk_idx), 0);
    chk("collide_nz", 64'(nz_mask), 0);
    for (int k = 0; k < 4; k++) blk(8'h60 + k, 1);
    rst_n = 0;
    mreset();
    #1;
    chk("arst_busy", 64'(busy), 0);
    chk("arst_idx", 64'(blk_idx), 0);
    chk("arst_nz", 64'(nz_mask), 0);
    chk("arst_done", 64'(done), 0);
    idle(2);
    rst_n = 1;
    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
